// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg: shared definitions for the key pulse generator.
//   - key_state_e : per-channel debounce FSM encoding
//   - Key*        : default timing constants (50 MHz board clock)
//   - max_u       : helper for sizing counters
package key_pulse_pkg;

    typedef enum logic [1:0] {
        StUp       = 2'd0,
        StDownPend = 2'd1,
        StDown     = 2'd2,
        StUpPend   = 2'd3
    } key_state_e;

    localparam int unsigned KeyDefNKeys          = 4;
    localparam int unsigned KeyDefDebounceCycles = 500000;    // 10 ms @ 50 MHz
    localparam int unsigned KeyDefRepeatDelay    = 25000000;  // 500 ms
    localparam int unsigned KeyDefRepeatPeriod   = 5000000;   // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: bundles raw key pins and the debounced outputs.
//   key         : raw active-low pins (0 = pressed), asynchronous
//   key_level   : debounced level, active-high
//   key_press   : 1-cycle press strobe (and auto-repeat strobes)
//   key_release : 1-cycle release strobe
// Modports: master = board/pin side, slave = the pulse generator.
interface key_pulse_gen_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output key,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchronizer, debounce FSM, registered
// level and press/release strobes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_raw     : raw active-low pin
//   key_level   : debounced level (1 = pressed)
//   key_press   : 1-cycle strobe on accepted press (and auto-repeat)
//   key_release : 1-cycle strobe on accepted release
// Build option: KEY_AUTOREPEAT_EN adds the auto-repeat counter and its parameters.
module key_debounce_ch
    import key_pulse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KeyDefDebounceCycles
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = KeyDefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = KeyDefRepeatPeriod
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic            ks;
    key_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;

    // Sync flops reset to 1 so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign ks = sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RptW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_q, rpt_d;
    logic            rpt_run_q, rpt_run_d;  // first repeat already emitted

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q     <= '0;
            rpt_run_q <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_run_q <= rpt_run_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;

        unique case (state_q)
            StUp: begin
                if (!ks) begin
                    state_d = StDownPend;
                    cnt_d   = CntW'(1);
                end
            end
            StDownPend: begin
                if (ks) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StDown;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDown: begin
                if (ks) begin
                    state_d = StUpPend;
                    cnt_d   = CntW'(1);
                end
            end
            StUpPend: begin
                if (!ks) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StUp;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StUp;
                cnt_d   = '0;
            end
        endcase

`ifdef KEY_AUTOREPEAT_EN
        // Repeat counter only advances while staying in DOWN; anything else clears it.
        rpt_d     = '0;
        rpt_run_d = 1'b0;
        if (state_q == StDown && !ks) begin
            rpt_run_d = rpt_run_q;
            if (rpt_q == (rpt_run_q ? PeriodLast : DelayLast)) begin
                rpt_run_d = 1'b1;
                press_d   = 1'b1;
            end else begin
                rpt_d = rpt_q + RptW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StUp;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: turns N_KEYS raw, bouncing, active-low key pins into debounced levels and
// one-cycle press/release strobes on clk. Channels are fully independent.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key_pulse_gen_if.slave (key in; key_level, key_press, key_release out)
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat press strobes while a key is held,
// and adds the REPEAT_DELAY / REPEAT_PERIOD parameters.
module key_pulse_gen
    import key_pulse_pkg::*;
#(
    parameter int unsigned N_KEYS          = KeyDefNKeys,
    parameter int unsigned DEBOUNCE_CYCLES = KeyDefDebounceCycles
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = KeyDefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = KeyDefRepeatPeriod
`endif
) (
    input logic             clk,
    input logic             rst_n,
    key_pulse_gen_if.slave  bus
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rel;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw     (bus.key[i]),
            .key_level   (level[i]),
            .key_press   (press[i]),
            .key_release (rel[i])
        );
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = rel;

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_pulse_gen_if #(.N_KEYS(NK)) kif ();

    key_pulse_gen #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif.slave)
    );

    typedef struct {
        logic [3:0] key;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int idx, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx, input logic [3:0] l,
                             input logic [3:0] p, input logic [3:0] r);
        check({name, "_level"}, idx, kif.key_level, l);
        check({name, "_press"}, idx, kif.key_press, p);
        check({name, "_release"}, idx, kif.key_release, r);
    endtask

    task automatic push(input logic [3:0] k, input logic [3:0] l, input logic [3:0] p,
                        input logic [3:0] r, input int n);
        vec_t v;
        v.key = k;
        v.lvl = l;
        v.prs = p;
        v.rel = r;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_rpt_edge(input int e);
`ifdef KEY_AUTOREPEAT_EN
        return (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25);
`else
        return (e == 6);
`endif
    endfunction

    initial begin
        // Each record: drive key, one clock edge, compare. A key change shows up
        // on the 6th compare counted from the record that drives it.
        push(4'hF, 4'h0, 4'h0, 4'h0, 20);                 // idle after reset
        push(4'hE, 4'h0, 4'h0, 4'h0, 5);                  // key0 press
        push(4'hE, 4'h1, 4'h1, 4'h0, 1);
        push(4'hE, 4'h1, 4'h0, 4'h0, 4);
        push(4'hF, 4'h1, 4'h0, 4'h0, 5);                  // key0 release
        push(4'hF, 4'h0, 4'h0, 4'h1, 1);
        push(4'hF, 4'h0, 4'h0, 4'h0, 4);
        push(4'hD, 4'h0, 4'h0, 4'h0, 3);                  // key1 bounce, 3 cycles
        push(4'hF, 4'h0, 4'h0, 4'h0, 10);
        push(4'hD, 4'h0, 4'h0, 4'h0, 4);                  // key1 low exactly 4 cycles
        push(4'hF, 4'h0, 4'h0, 4'h0, 1);
        push(4'hF, 4'h2, 4'h2, 4'h0, 1);
        push(4'hF, 4'h2, 4'h0, 4'h0, 3);
        push(4'hF, 4'h0, 4'h0, 4'h2, 1);
        push(4'hF, 4'h0, 4'h0, 4'h0, 4);
        push(4'h6, 4'h0, 4'h0, 4'h0, 5);                  // key0 + key3 together
        push(4'h6, 4'h9, 4'h9, 4'h0, 1);
        push(4'h6, 4'h9, 4'h0, 4'h0, 4);
        push(4'hF, 4'h9, 4'h0, 4'h0, 5);
        push(4'hF, 4'h0, 4'h0, 4'h9, 1);
        push(4'hF, 4'h0, 4'h0, 4'h0, 4);

        kif.key = 4'hF;
        rst_n   = 1'b0;
        repeat (3) step();
        check_all("reset", 0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            kif.key = vecs[i].key;
            step();
            check_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
        end

        // Reset pulsed while key2 is mid-debounce.
        kif.key = 4'hB;
        repeat (3) step();
        check_all("t4_pend", 0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("t4_rst", 0, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 2; i++) begin
            step();
            check_all("t4_rst", i, 4'h0, 4'h0, 4'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check_all("t4_after", e, (e >= 6) ? 4'h4 : 4'h0, (e == 6) ? 4'h4 : 4'h0, 4'h0);
        end
        kif.key = 4'hF;
        for (int e = 1; e <= 7; e++) begin
            step();
            check_all("t4_rel", e, (e < 6) ? 4'h4 : 4'h0, 4'h0, (e == 6) ? 4'h4 : 4'h0);
        end

        // Long hold of key0: auto-repeat strobes when enabled, single press otherwise.
        kif.key = 4'hE;
        for (int e = 1; e <= 31; e++) begin
            if (e == 25) kif.key = 4'hF;
            step();
            check_all("t6_hold", e, (e >= 6 && e < 30) ? 4'h1 : 4'h0,
                      is_rpt_edge(e) ? 4'h1 : 4'h0, (e == 30) ? 4'h1 : 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
